// File: rtl/pipecleaner_alu_if.sv
// Operand/result handshake bundle for pipecleaner_alu: one valid/ready beat
// in, one valid/ready result out.
interface pipecleaner_alu_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [1:0]           in_mode;
  logic                 acc_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_carry;
  logic                 out_sat;

  modport master (
    output in_valid, in_a, in_b, in_mode, acc_clr, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, acc_clr, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_sat
  );
endinterface

// File: rtl/pipecleaner_alu.sv
// Registered ADD/SUB/SATADD/ACC unit with a single result register and
// valid/ready backpressure; the only combinational path is out_ready -> in_ready.
module pipecleaner_alu #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  pipecleaner_alu_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_ADD    = 2'd0,
    MODE_SUB    = 2'd1,
    MODE_SATADD = 2'd2,
    MODE_ACC    = 2'd3
  } mode_e;

  if (ACC_WIDTH < WIDTH + 1) begin : g_width_check
    $error("pipecleaner_alu: ACC_WIDTH must be at least WIDTH+1");
  end

  logic                 out_valid_r;
  logic [ACC_WIDTH-1:0] out_data_r;
  logic                 out_carry_r;
  logic                 out_sat_r;
  logic [ACC_WIDTH-1:0] acc_r;

  logic                 accept_s;
  logic                 consume_s;
  mode_e                mode_s;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       diff_s;
  logic [ACC_WIDTH-1:0] acc_base_s;
  logic [ACC_WIDTH:0]   acc_sum_s;
  logic [ACC_WIDTH-1:0] res_data_s;
  logic                 res_carry_s;
  logic                 res_sat_s;

  assign bus.in_ready  = !out_valid_r || bus.out_ready;
  assign accept_s      = bus.in_valid && bus.in_ready;
  assign consume_s     = out_valid_r && bus.out_ready;
  assign mode_s        = mode_e'(bus.in_mode);

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_carry = out_carry_r;
  assign bus.out_sat   = out_sat_r;

  // Next-result datapath; a clear in the same cycle zeroes the accumulate base.
  always_comb begin
    sum_s       = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    diff_s      = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    acc_base_s  = bus.acc_clr ? {ACC_WIDTH{1'b0}} : acc_r;
    acc_sum_s   = {1'b0, acc_base_s} + (ACC_WIDTH + 1)'(sum_s);
    res_data_s  = {ACC_WIDTH{1'b0}};
    res_carry_s = 1'b0;
    res_sat_s   = 1'b0;
    case (mode_s)
      MODE_ADD: begin
        res_data_s  = ACC_WIDTH'(sum_s);
        res_carry_s = sum_s[WIDTH];
      end
      MODE_SUB: begin
        // Top bit of the (WIDTH+1)-bit difference is the borrow.
        res_data_s  = ACC_WIDTH'(diff_s[WIDTH-1:0]);
        res_carry_s = diff_s[WIDTH];
      end
      MODE_SATADD: begin
        if (sum_s[WIDTH]) begin
          res_data_s = ACC_WIDTH'({WIDTH{1'b1}});
          res_sat_s  = 1'b1;
        end else begin
          res_data_s = ACC_WIDTH'(sum_s[WIDTH-1:0]);
          res_sat_s  = 1'b0;
        end
      end
      MODE_ACC: begin
        res_data_s  = acc_sum_s[ACC_WIDTH-1:0];
        res_carry_s = acc_sum_s[ACC_WIDTH];
      end
      default: begin
        res_data_s  = {ACC_WIDTH{1'b0}};
        res_carry_s = 1'b0;
        res_sat_s   = 1'b0;
      end
    endcase
  end

  // Result register and accumulator state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {ACC_WIDTH{1'b0}};
      out_carry_r <= 1'b0;
      out_sat_r   <= 1'b0;
      acc_r       <= {ACC_WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= res_data_s;
        out_carry_r <= res_carry_s;
        out_sat_r   <= res_sat_s;
      end else if (consume_s) begin
        out_valid_r <= 1'b0;
      end
      if (accept_s && (mode_s == MODE_ACC)) begin
        acc_r <= acc_sum_s[ACC_WIDTH-1:0];
      end else if (bus.acc_clr) begin
        acc_r <= {ACC_WIDTH{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_pipecleaner_alu.sv
// Scoreboard bench for pipecleaner_alu: directed beats push expected results,
// an independent monitor pops and compares on every consumed result.
module tb_pipecleaner_alu;
  localparam int W  = 8;
  localparam int AW = 16;
  localparam logic [1:0] M_ADD = 2'd0;
  localparam logic [1:0] M_SUB = 2'd1;
  localparam logic [1:0] M_SAT = 2'd2;
  localparam logic [1:0] M_ACC = 2'd3;

  typedef struct packed {
    logic [AW-1:0] data;
    logic          carry;
    logic          sat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  pipecleaner_alu_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus ();

  pipecleaner_alu #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each consumed result against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=0x%0h required=none", bus.out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e.data));
        check("out_carry", 32'(bus.out_carry), 32'(e.carry));
        check("out_sat", 32'(bus.out_sat), 32'(e.sat));
      end
    end
  end

  // Drive one beat (called at posedge+1); leaves in_valid asserted on return.
  task automatic send(input logic [1:0] mode, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic clr, input logic [AW-1:0] d, input logic c, input logic s);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.acc_clr  = clr;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        sb.push_back('{data: d, carry: c, sat: s});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    bus.acc_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW:0] model;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'd0;
    bus.in_b      = 8'd0;
    bus.in_mode   = 2'd0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(M_ADD, 8'd200, 8'd100, 1'b0, 16'h012C, 1'b1, 1'b0);
    send(M_ADD, 8'd3,   8'd4,   1'b0, 16'h0007, 1'b0, 1'b0);
    send(M_SUB, 8'd5,   8'd7,   1'b0, 16'h00FE, 1'b1, 1'b0);
    send(M_SUB, 8'd7,   8'd5,   1'b0, 16'h0002, 1'b0, 1'b0);
    send(M_SAT, 8'd200, 8'd100, 1'b0, 16'h00FF, 1'b0, 1'b1);
    send(M_SAT, 8'd100, 8'd50,  1'b0, 16'h0096, 1'b0, 1'b0);
    idle(2);

    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;

    // 129 back-to-back ACC beats of 0xFF+0xFF; beats 128/129 use hand values.
    model = 17'd0;
    for (int k = 1; k <= 129; k++) begin
      model = {1'b0, model[AW-1:0]} + 17'd510;
      if (k == 128)      send(M_ACC, 8'hFF, 8'hFF, 1'b0, 16'hFF00, 1'b0, 1'b0);
      else if (k == 129) send(M_ACC, 8'hFF, 8'hFF, 1'b0, 16'h00FE, 1'b1, 1'b0);
      else               send(M_ACC, 8'hFF, 8'hFF, 1'b0, model[AW-1:0], model[AW], 1'b0);
    end
    send(M_ACC, 8'd1, 8'd2, 1'b1, 16'h0003, 1'b0, 1'b0);
    idle(2);

    // Backpressure: result 5 held for three cycles with a pending ACC 1+1 beat.
    bus.out_ready = 1'b0;
    send(M_ACC, 8'd1, 8'd1, 1'b0, 16'h0005, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_out_data", 32'(bus.out_data), 32'h0005);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    sb.push_back('{data: 16'h0007, carry: 1'b0, sat: 1'b0});
    @(posedge clk);
    #1;
    idle(2);

    // Reset during a stall discards the held result and the accumulator.
    bus.out_ready = 1'b0;
    send(M_ACC, 8'd1, 8'd1, 1'b0, 16'h0009, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_out_data", 32'(bus.out_data), 32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(M_ACC, 8'd1, 8'd0, 1'b0, 16'h0001, 1'b0, 1'b0);
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
